// File: rtl/kgp_ctrl_if.sv
// Bus between the KGPRISC multi-cycle sequencer and the datapath/memories:
// run control, IR, memory acks and branch flag in; phase-gated strobes out.
interface kgp_ctrl_if #(parameter int CNT_W = 16);
  logic             start;
  logic [31:0]      instr;
  logic             imem_ack;
  logic             dmem_ack;
  logic             zero_flag;
  logic             imem_req;
  logic             ir_load;
  logic             pc_write;
  logic [1:0]       pc_src;
  logic             dmem_req;
  logic             Branch;
  logic             MemRead;
  logic             MemtoReg;
  logic             ALUop;
  logic             MemWrite;
  logic             ALUsrc;
  logic             RegWrite;
  logic             ra_RegWrite;
  logic             busy;
  logic             trap;
  logic [CNT_W-1:0] retired;

  modport master (
    input  start, instr, imem_ack, dmem_ack, zero_flag,
    output imem_req, ir_load, pc_write, pc_src, dmem_req,
           Branch, MemRead, MemtoReg, ALUop, MemWrite, ALUsrc, RegWrite, ra_RegWrite,
           busy, trap, retired
  );

  modport slave (
    output start, instr, imem_ack, dmem_ack, zero_flag,
    input  imem_req, ir_load, pc_write, pc_src, dmem_req,
           Branch, MemRead, MemtoReg, ALUop, MemWrite, ALUsrc, RegWrite, ra_RegWrite,
           busy, trap, retired
  );
endinterface

// File: rtl/kgp_ctrl_fsm.sv
// Multi-cycle KGPRISC control sequencer: steps each instruction through
// fetch/decode/execute/memory/writeback and gates decoder strobes to their phase.
//
// state  | meaning
// IDLE   | stopped, waiting for start
// FETCH  | instruction memory request, waits for imem_ack
// DECODE | latch opcode, reject illegal opcodes
// EXEC   | ALU / branch / jump / call / return
// MEM    | data memory access for LW/SW, waits for dmem_ack
// WB     | register writeback, PC+4
// TRAP   | sticky fault, left only through rst
module kgp_ctrl_fsm #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 16
) (
  input logic        clk,
  input logic        rst,
  kgp_ctrl_if.master bus
);
  localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  localparam logic [5:0] OP_ALUR = 6'd0;
  localparam logic [5:0] OP_ALUI = 6'd1;
  localparam logic [5:0] OP_LW   = 6'd2;
  localparam logic [5:0] OP_SW   = 6'd3;
  localparam logic [5:0] OP_BR   = 6'd4;
  localparam logic [5:0] OP_JMP  = 6'd5;
  localparam logic [5:0] OP_CALL = 6'd6;
  localparam logic [5:0] OP_RET  = 6'd7;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
  } state_t;

  state_t            state;
  logic [5:0]        op_q;
  logic [WAIT_W-1:0] wait_cnt;
  logic [CNT_W-1:0]  retired_q;
  logic              retire;
  logic              is_ctl;
  logic              illegal;
  logic              unused_instr_bits;

  assign is_ctl            = (op_q == OP_BR) || (op_q == OP_JMP) || (op_q == OP_CALL) || (op_q == OP_RET);
  assign illegal           = (bus.instr[31:29] != 3'b000);
  assign unused_instr_bits = ^bus.instr[25:0];

  always_comb begin
    retire = 1'b0;
    case (state)
      S_EXEC:  retire = is_ctl;
      S_MEM:   retire = (op_q == OP_SW) && bus.dmem_ack;
      S_WB:    retire = 1'b1;
      default: retire = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      op_q      <= '0;
      wait_cnt  <= '0;
      retired_q <= '0;
    end else if (retire) begin
      retired_q <= retired_q + CNT_W'(1);
      wait_cnt  <= '0;
      state     <= bus.start ? S_FETCH : S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            state    <= S_FETCH;
            wait_cnt <= '0;
          end
        end
        S_FETCH: begin
          // an ack on the last allowed cycle still wins over the timeout
          if (bus.imem_ack)              state    <= S_DECODE;
          else if (wait_cnt == WAIT_LAST) state   <= S_TRAP;
          else                           wait_cnt <= wait_cnt + WAIT_W'(1);
        end
        S_DECODE: begin
          op_q  <= bus.instr[31:26];
          state <= illegal ? S_TRAP : S_EXEC;
        end
        S_EXEC: begin
          if ((op_q == OP_LW) || (op_q == OP_SW)) begin
            state    <= S_MEM;
            wait_cnt <= '0;
          end else begin
            state <= S_WB;
          end
        end
        S_MEM: begin
          if (bus.dmem_ack)              state    <= S_WB;
          else if (wait_cnt == WAIT_LAST) state   <= S_TRAP;
          else                           wait_cnt <= wait_cnt + WAIT_W'(1);
        end
        S_WB:    state <= S_WB;
        S_TRAP:  state <= S_TRAP;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    bus.imem_req    = 1'b0;
    bus.ir_load     = 1'b0;
    bus.pc_write    = 1'b0;
    bus.pc_src      = 2'b00;
    bus.dmem_req    = 1'b0;
    bus.Branch      = 1'b0;
    bus.MemRead     = 1'b0;
    bus.MemtoReg    = 1'b0;
    bus.ALUop       = 1'b0;
    bus.MemWrite    = 1'b0;
    bus.ALUsrc      = 1'b0;
    bus.RegWrite    = 1'b0;
    bus.ra_RegWrite = 1'b0;
    case (state)
      S_FETCH: begin
        bus.imem_req = 1'b1;
        bus.ir_load  = bus.imem_ack;
      end
      S_EXEC: begin
        bus.ALUop  = (op_q == OP_ALUR) || (op_q == OP_ALUI);
        bus.ALUsrc = (op_q == OP_ALUI) || (op_q == OP_LW) || (op_q == OP_SW);
        case (op_q)
          OP_BR: begin
            bus.Branch   = 1'b1;
            bus.pc_src   = 2'b01;
            bus.pc_write = bus.zero_flag;
          end
          OP_JMP: begin
            bus.pc_write = 1'b1;
            bus.pc_src   = 2'b10;
          end
          OP_CALL: begin
            bus.pc_write    = 1'b1;
            bus.pc_src      = 2'b10;
            bus.ra_RegWrite = 1'b1;
          end
          OP_RET: begin
            bus.pc_write = 1'b1;
            bus.pc_src   = 2'b11;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        bus.dmem_req = 1'b1;
        bus.MemRead  = (op_q == OP_LW);
        bus.MemWrite = (op_q == OP_SW);
        bus.pc_write = (op_q == OP_SW) && bus.dmem_ack;
      end
      S_WB: begin
        bus.RegWrite = 1'b1;
        bus.MemtoReg = (op_q == OP_LW);
        bus.pc_write = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.busy    = (state != S_IDLE) && (state != S_TRAP);
  assign bus.trap    = (state == S_TRAP);
  assign bus.retired = retired_q;
endmodule

// File: doc/kgp_ctrl_fsm.md
Name: kgp_ctrl_fsm

Overview:
Multi-cycle control sequencer for the KGPRISC core. It steps each instruction through fetch, decode, execute, memory and writeback. It drives the same control strobes the instruction decoder produces (Branch, MemRead, MemtoReg, ALUop, MemWrite, ALUsrc, RegWrite, ra_RegWrite), but gates each one to its correct phase. It also handshakes with instruction and data memory, and steers PC update. It sits between the IR/PC registers, the register file, the ALU and the memories.

Parameters:
TIMEOUT, 16, maximum cycles to wait for imem_ack or dmem_ack before trapping (must be >= 1).
CNT_W, 16, width of the retired-instruction counter.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous, active-high reset.
start  in  1  run enable, level-sensitive; sampled in IDLE and at every retire.
instr  in  32  current IR contents; opcode is instr[31:26].
imem_ack  in  1  instruction memory has data valid for the current request.
dmem_ack  in  1  data memory access complete.
zero_flag  in  1  ALU branch condition.
imem_req  out  1  instruction fetch request.
ir_load  out  1  load IR from instruction memory.
pc_write  out  1  PC update enable.
pc_src  out  2  PC source select: 00 = PC+4, 01 = branch target, 10 = jump target, 11 = ra.
dmem_req  out  1  data memory request.
Branch, MemRead, MemtoReg, ALUop, MemWrite, ALUsrc, RegWrite, ra_RegWrite  out  1 each  phase-gated datapath controls.
busy  out  1  high in every state except IDLE and TRAP.
trap  out  1  sticky fault indicator.
retired  out  CNT_W  count of completed instructions.

Behaviour:
- Reset: asynchronous; takes effect immediately, including mid-instruction.
  - State goes to IDLE; retired = 0; trap = 0; wait counter = 0.
  - All outputs are 0 while rst is high and on the first cycle after release.
- Outputs are combinational functions of the state register, the latched opcode op_q, and the acks/zero_flag. Any output not listed for a state is 0.
- Opcode classes:
  - 000000 ALU reg-reg
  - 000001 ALU immediate
  - 000010 LW
  - 000011 SW
  - 000100 BR (conditional branch)
  - 000101 JMP
  - 000110 CALL
  - 000111 RET
  - all other opcodes are illegal.
- IDLE: if start = 1, go to FETCH.
- FETCH:
  - imem_req = 1.
  - On imem_ack: ir_load = 1 in that same cycle, then go to DECODE.
- DECODE: latch op_q <= instr[31:26]. Illegal opcode goes to TRAP; otherwise go to EXEC.
- EXEC:
  - ALUop = 1 for both ALU classes.
  - ALUsrc = 1 for ALU immediate, LW and SW.
  - BR: Branch = 1, pc_src = 01, pc_write = zero_flag; retire.
  - JMP: pc_write = 1, pc_src = 10; retire.
  - CALL: pc_write = 1, pc_src = 10, ra_RegWrite = 1; retire.
  - RET: pc_write = 1, pc_src = 11; retire.
  - LW/SW go to MEM; ALU classes go to WB.
- MEM:
  - dmem_req = 1; MemRead = 1 for LW, MemWrite = 1 for SW; both held until dmem_ack.
  - On ack, LW goes to WB.
  - On ack, SW sets pc_write = 1, pc_src = 00, and retires.
- WB: RegWrite = 1; MemtoReg = 1 for LW; pc_write = 1, pc_src = 00; retire.
- Retire cycle:
  - retired increments by 1, wrapping modulo 2^CNT_W.
  - Next state is FETCH if start = 1, else IDLE.
- Wait counter:
  - Cleared on entry to FETCH and to MEM.
  - Counts cycles spent waiting without an ack.
  - If no ack by the end of the TIMEOUT-th cycle in the state, next state is TRAP.
  - An ack arriving on the TIMEOUT-th cycle is accepted (ack beats timeout).
- TRAP: trap = 1, busy = 0; all strobes are 0; only rst exits this state.
- Latency with zero-wait acks, in cycles from entering FETCH to retire inclusive:
  - ALU: 4
  - LW: 5
  - SW: 4
  - BR/JMP/CALL/RET: 3
- Each additional wait cycle on imem_ack or dmem_ack adds exactly 1 cycle.

Test Plan:
- rst pulse; start=1; instr=32'b00000010101101011010100000000000; acks tied high -> states FETCH, DECODE, EXEC, WB; ALUop=1 only in EXEC; RegWrite=1 only in WB with pc_src=00; retired=1 after 4 cycles; then drop start -> IDLE, busy=0.
- instr=32'b00001010101000000000000000000100 (LW); dmem_ack raised on 4th MEM cycle -> MemRead and dmem_req high for 4 cycles, ALUsrc=1 in EXEC, MemtoReg=RegWrite=1 in WB; retire at cycle 8.
- BR opcode 000100 run twice, zero_flag=1 then 0 -> Branch=1, pc_src=01 in EXEC both times; pc_write=1 then 0; each retires in 3 cycles.
- CALL (000110) then RET (000111) -> CALL EXEC: ra_RegWrite=1, pc_src=10; RET EXEC: pc_src=11, ra_RegWrite=0; retired advances by 2.
- TIMEOUT=16, imem_ack held 0 -> imem_req high for exactly 16 cycles, trap=1 on the 17th; trap stays 1 for 50 more cycles despite start=1; cleared only by rst. Repeat with ack on cycle 16 -> accepted, no trap.
- Illegal opcode 111111 -> TRAP after DECODE with no strobes issued; separately, assert rst mid-MEM of an SW -> MemWrite and dmem_req drop to 0 in the same timestep; retired=0.
